jtag_dbg_sysclk_cmdq: RTL and testbench
=======================================

Name: jtag_dbg_sysclk_cmdq

Overview:
- System-clock side of the CPU JTAG debug module, generalised in IR width, DR width and queue depth.
- Resynchronises the virtual-JTAG update-IR and update-DR strobes into `clk`.
- Captures the TCK-domain shift register and IR on each update-DR, and queues the result as commands in a DEPTH-entry FIFO.
- Presents commands to the OCI/break/trace logic with a valid/ready handshake, so back-to-back JTAG updates are not lost while the core is busy. Overflow is flagged with a sticky bit.

Parameters:
- IR_W, 2, width of virtual-JTAG instruction register.
- DR_W, 38, width of shift register `sr` and of command data.
- DEPTH, 4, command FIFO entries; a power of two, 2..16.
- SYNC_STAGES, 2, synchroniser flops per strobe, 2..4.
- ACT_BIT, 35, index of the `sr` bit that selects take_action (1) vs take_no_action (0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ir_in  in  IR_W  TCK-domain IR; stable while vs_uir/vs_udr are high.
- sr  in  DR_W  TCK-domain shift register; stable while vs_udr is high.
- vs_uir  in  1  virtual update-IR level, asynchronous to clk.
- vs_udr  in  1  virtual update-DR level, asynchronous to clk.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head command.
- cmd_ir  out  IR_W  IR of the head command.
- cmd_take  out  1  sr[ACT_BIT] of the head command.
- jdo  out  DR_W  data of the head command.
- ir_q  out  IR_W  latest IR, resynchronised on update-IR.
- fill  out  $clog2(DEPTH+1)  FIFO occupancy.
- overrun  out  1  sticky: a command was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset, asynchronous:
  - All synchroniser flops and edge-detect history flops load 1. A strobe held high across reset release therefore produces no edge.
  - FIFO is emptied.
  - cmd_valid=0, cmd_ir=0, cmd_take=0, jdo=0, ir_q=0, fill=0, overrun=0.
- Synchroniser: each strobe passes through SYNC_STAGES flops. An edge is defined as synced=1 and history=0, and history registers the synced value every cycle.
- Update-IR edge: ir_q <= ir_in on the same cycle as the edge.
- Update-DR edge: push {ir_in, sr} into the FIFO on the same cycle as the edge. This captures ir_in directly, not ir_q.
- Latency:
  - vs_udr rises before clk edge 0 (first clk edge that samples it high).
  - Edge detected at edge SYNC_STAGES.
  - With the FIFO empty, cmd_valid=1 after edge SYNC_STAGES+1.
  - Same timing for ir_q on update-IR.
- Head outputs are registered and always reflect the FIFO head. When the FIFO is empty, cmd_ir/cmd_take/jdo hold their last values.
- Handshake:
  - Pop occurs when cmd_valid && cmd_ready.
  - cmd_valid may not drop without a pop.
  - The head is stable while cmd_valid && !cmd_ready.
  - The next entry appears on the cycle after a pop; cmd_valid stays 1 if fill>1.
- fill: +1 on push-only, −1 on pop-only, unchanged on push+pop.
- Full (fill==DEPTH):
  - Push without a same-cycle pop: the command is dropped, FIFO unchanged, overrun<=1.
  - Push with a same-cycle pop: accepted, fill stays DEPTH, no overrun.
- Empty with a same-cycle push: normal push. cmd_ready is ignored while cmd_valid=0.
- overrun set and clr_overrun in the same cycle: set wins.
- Pointers wrap modulo DEPTH.
- Minimum command spacing: update-DR edges less than 2 clk cycles apart cannot be resolved and are outside scope. This is guaranteed by the TCK/clk ratio.
- No combinational path from any input to any output.

Test Plan:
- Reset with vs_udr=1 held, then release; hold 10 cycles -> cmd_valid stays 0, fill=0.
- ir_in=2'b10, sr=38'h08_0000_1234 (bit35=1), pulse vs_udr high for 6 clk, cmd_ready=1 -> cmd_valid=1 for exactly 1 cycle, at edge SYNC_STAGES+1. That cycle shows cmd_ir=2'b10, cmd_take=1, jdo=38'h08_0000_1234; fill returns to 0.
- cmd_ready=0, issue 5 update-DRs with sr=1..5 (DEPTH=4) -> fill=4, overrun=1. Then cmd_ready=1 -> jdo sequence is 1,2,3,4, and 5 is never seen.
- FIFO full, push coincides with pop -> fill stays 4, overrun unchanged, the new entry is delivered last in order.
- overrun=1; assert clr_overrun on the same cycle a dropped push occurs -> overrun stays 1. clr_overrun alone -> overrun=0.
- vs_uir pulse with ir_in=2'b01 -> ir_q=2'b01 after SYNC_STAGES+1 edges. Assert reset mid-queue with fill=3 -> all outputs zero immediately, asynchronously.

Source files
------------

// File: rtl/jtag_dbg_sysclk_cmdq.sv
`default_nettype none
// ============================================================================
// jtag_dbg_sysclk_cmdq : clk-side JTAG debug command queue (strobe resync,
// update-DR capture into a FIFO, valid/ready head).   Revision 1.0
// ============================================================================
module jtag_dbg_sysclk_cmdq #(
   parameter int IR_W        = 2,
   parameter int DR_W        = 38,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ACT_BIT     = 35
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [IR_W-1:0]              ir_in,
   input  logic [DR_W-1:0]              sr,
   input  logic                         vs_uir,
   input  logic                         vs_udr,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic [IR_W-1:0]              cmd_ir,
   output logic                         cmd_take,
   output logic [DR_W-1:0]              jdo,
   output logic [IR_W-1:0]              ir_q,
   output logic [$clog2(DEPTH+1)-1:0]   fill,
   output logic                         overrun,
   input  logic                         clr_overrun
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = $clog2(DEPTH + 1);
   localparam int EW = IR_W + DR_W;
   localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
   logic                   uir_hist_q, uir_hist_d;
   logic                   udr_hist_q, udr_hist_d;
   logic [EW-1:0]          mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]          fill_q, fill_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
   logic                   cmd_take_q, cmd_take_d;
   logic [DR_W-1:0]        jdo_q, jdo_d;
   logic [IR_W-1:0]        ir_latest_q, ir_latest_d;
   logic                   overrun_q, overrun_d;

   logic                   uir_edge, udr_edge;
   logic                   pop, push, full;
   logic [EW-1:0]          head;

   always_comb begin
      uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_hist_d = uir_sync_q[SYNC_STAGES-1];
      udr_hist_d = udr_sync_q[SYNC_STAGES-1];
      uir_edge   = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
      udr_edge   = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;

      pop  = cmd_valid_q & cmd_ready;
      full = (fill_q == FULL_CNT);
      // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
      push = udr_edge & (~full | pop);

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      fill_d   = fill_q + FW'(push) - FW'(pop);

      // Entries pushed this cycle are not counted: the head register sees them
      // one cycle later, which keeps the memory read free of a write bypass.
      cmd_valid_d = (fill_q > FW'(pop));
      head        = mem_q[rd_ptr_d];
      cmd_ir_d    = cmd_ir_q;
      cmd_take_d  = cmd_take_q;
      jdo_d       = jdo_q;
      if (cmd_valid_d) begin
         cmd_ir_d   = head[EW-1:DR_W];
         jdo_d      = head[DR_W-1:0];
         cmd_take_d = head[ACT_BIT];
      end

      ir_latest_d = uir_edge ? ir_in : ir_latest_q;

      overrun_d = overrun_q;
      if (udr_edge & full & ~pop) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   // Synchroniser and history flops reset high so a strobe already high at
   // reset release does not register as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uir_sync_q  <= '1;
         udr_sync_q  <= '1;
         uir_hist_q  <= 1'b1;
         udr_hist_q  <= 1'b1;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_ir_q    <= '0;
         cmd_take_q  <= 1'b0;
         jdo_q       <= '0;
         ir_latest_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         uir_sync_q  <= uir_sync_d;
         udr_sync_q  <= udr_sync_d;
         uir_hist_q  <= uir_hist_d;
         udr_hist_q  <= udr_hist_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_ir_q    <= cmd_ir_d;
         cmd_take_q  <= cmd_take_d;
         jdo_q       <= jdo_d;
         ir_latest_q <= ir_latest_d;
         overrun_q   <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {ir_in, sr};
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_ir    = cmd_ir_q;
   assign cmd_take  = cmd_take_q;
   assign jdo       = jdo_q;
   assign ir_q      = ir_latest_q;
   assign fill      = fill_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dbg_sysclk_cmdq.sv
`default_nettype none
// ============================================================================
// tb_jtag_dbg_sysclk_cmdq : directed bench with an expected-command queue.
// Revision 1.0
// ============================================================================
module tb_jtag_dbg_sysclk_cmdq;

   localparam int IR_W    = 2;
   localparam int DR_W    = 38;
   localparam int DEPTH   = 4;
   localparam int SYNC    = 2;
   localparam int ACT_BIT = 35;
   localparam int FW      = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic [IR_W-1:0] ir_in;
   logic [DR_W-1:0] sr;
   logic            vs_uir, vs_udr;
   logic            cmd_valid, cmd_ready;
   logic [IR_W-1:0] cmd_ir;
   logic            cmd_take;
   logic [DR_W-1:0] jdo;
   logic [IR_W-1:0] ir_q;
   logic [FW-1:0]   fill;
   logic            overrun, clr_overrun;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   logic [IR_W+DR_W-1:0] exp_q[$];

   jtag_dbg_sysclk_cmdq #(
      .IR_W(IR_W), .DR_W(DR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .ACT_BIT(ACT_BIT)
   ) dut (
      .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
      .vs_udr(vs_udr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_take(cmd_take), .jdo(jdo), .ir_q(ir_q),
      .fill(fill), .overrun(overrun), .clr_overrun(clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare the head against the scoreboard whenever the coming edge pops.
   task automatic tick();
      logic [IR_W+DR_W-1:0] e;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_pop observed jdo=%0h expected no command", jdo);
         end else begin
            e = exp_q.pop_front();
            chk("pop_ir",   64'(cmd_ir),   64'(e[IR_W+DR_W-1:DR_W]));
            chk("pop_take", 64'(cmd_take), 64'(e[ACT_BIT]));
            chk("pop_jdo",  64'(jdo),      64'(e[DR_W-1:0]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic udr(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] d, input bit expect_kept);
      ir_in = ir;
      sr    = d;
      if (expect_kept) exp_q.push_back({ir, d});
      vs_udr = 1'b1;
      repeat (3) tick();
      vs_udr = 1'b0;
      repeat (3) tick();
   endtask

   task automatic drain();
      cmd_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      repeat (4) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_fill",  64'(fill), 64'd0);
      chk("drain_valid", 64'(cmd_valid), 64'd0);
   endtask

   initial begin
      int vcount;
      int vidx;
      reset = 1'b1; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b1;
      cmd_ready = 1'b0; clr_overrun = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid",   64'(cmd_valid), 64'd0);
      chk("rst_fill",    64'(fill), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_jdo",     64'(jdo), 64'd0);
      chk("rst_irq",     64'(ir_q), 64'd0);
      reset = 1'b0;
      vcount = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cmd_valid) vcount++;
      end
      chk("held_udr_valid_cycles", 64'(vcount), 64'd0);
      chk("held_udr_fill", 64'(fill), 64'd0);
      vs_udr = 1'b0;
      repeat (4) tick();

      // Single command, consumer always ready: valid for one cycle after edge SYNC+1.
      cmd_ready = 1'b1;
      ir_in = 2'b10;
      sr    = 38'h08_0000_1234;
      exp_q.push_back({2'b10, 38'h08_0000_1234});
      vs_udr = 1'b1;
      vcount = 0;
      vidx   = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cmd_valid) begin
            vcount++;
            vidx = i;
            chk("single_ir",   64'(cmd_ir), 64'd2);
            chk("single_take", 64'(cmd_take), 64'd1);
            chk("single_jdo",  64'(jdo), 64'h08_0000_1234);
         end
         if (i == 5) vs_udr = 1'b0;
      end
      chk("single_valid_cycles", 64'(vcount), 64'd1);
      chk("single_valid_edge",   64'(vidx), 64'(SYNC + 1));
      chk("single_fill", 64'(fill), 64'd0);
      chk("single_sb_empty", 64'(exp_q.size()), 64'd0);

      // Five commands into a four-deep queue while stalled.
      cmd_ready = 1'b0;
      for (int k = 1; k <= 4; k++) udr(2'b01, DR_W'(k), 1'b1);
      chk("four_fill", 64'(fill), 64'd4);
      chk("four_overrun", 64'(overrun), 64'd0);
      chk("stall_head_jdo", 64'(jdo), 64'd1);
      udr(2'b01, DR_W'(5), 1'b0);
      chk("five_fill", 64'(fill), 64'd4);
      chk("five_overrun", 64'(overrun), 64'd1);
      chk("stall_head_jdo2", 64'(jdo), 64'd1);
      pops = 0;
      drain();
      chk("five_pop_count", 64'(pops), 64'd4);

      // Refill, then a dropped push with clr_overrun in the same cycle.
      cmd_ready = 1'b0;
      for (int k = 11; k <= 14; k++) udr(2'b11, DR_W'(k) | (38'd1 << ACT_BIT), 1'b1);
      chk("refill_fill", 64'(fill), 64'd4);
      ir_in = 2'b00; sr = DR_W'(99); vs_udr = 1'b1;
      tick(); tick();
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("set_beats_clr", 64'(overrun), 64'd1);
      chk("drop_fill", 64'(fill), 64'd4);
      vs_udr = 1'b0;
      repeat (3) tick();
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("clr_alone", 64'(overrun), 64'd0);

      // Push coinciding with a pop on a full queue.
      ir_in = 2'b10; sr = DR_W'(15); vs_udr = 1'b1;
      exp_q.push_back({2'b10, DR_W'(15)});
      tick(); tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("pushpop_fill", 64'(fill), 64'd4);
      chk("pushpop_overrun", 64'(overrun), 64'd0);
      vs_udr = 1'b0;
      repeat (3) tick();
      pops = 0;
      drain();
      chk("pushpop_pop_count", 64'(pops), 64'd4);

      // Update-IR resynchronisation.
      ir_in = 2'b01; vs_uir = 1'b1;
      tick(); tick();
      chk("uir_before_edge", 64'(ir_q), 64'd0);
      tick();
      chk("uir_after_edge", 64'(ir_q), 64'd1);
      vs_uir = 1'b0;
      repeat (3) tick();

      // Asynchronous reset with three commands queued.
      cmd_ready = 1'b0;
      for (int k = 21; k <= 23; k++) udr(2'b11, DR_W'(k), 1'b1);
      chk("pre_reset_fill", 64'(fill), 64'd3);
      chk("pre_reset_valid", 64'(cmd_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      exp_q.delete();
      chk("async_valid",   64'(cmd_valid), 64'd0);
      chk("async_fill",    64'(fill), 64'd0);
      chk("async_jdo",     64'(jdo), 64'd0);
      chk("async_ir",      64'(cmd_ir), 64'd0);
      chk("async_take",    64'(cmd_take), 64'd0);
      chk("async_irq",     64'(ir_q), 64'd0);
      chk("async_overrun", 64'(overrun), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) tick();
      chk("post_reset_valid", 64'(cmd_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
